// File: rtl/pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_stall_ctrl
// Central stall/flush control for the five-stage MIPS pipeline.
//
// The block combines the load-use request from ID, the divide wait in EX and
// the data SRAM wait in MEM into one StallBus. It also sequences exception
// flushes and drives the redirect PC.
//
// StallBus bits: 0 PC, 1 IF/ID, 2 ID/EX, 3 EX/MEM, 4 MEM/WB, 5 WB (1 = hold).
// Only the highest-priority cause drives the bus, in the order
// FLUSH > MEM > EX > ID. The causes are never OR-merged.
//
// A divide keeps the pipeline stalled for at most DIV_TIMEOUT cycles,
// counting from the cycle that accepts div_start. If div_ready has not
// arrived by then, div_timeout and div_cancel pulse together in the
// following cycle.
//
// div_cancel and div_timeout are registered pulses. They appear in the
// cycle after the event that caused them. An exception taken during a
// divide wait therefore shows div_cancel in the first flush cycle.
//
// Optional build macro STALL_PERF_EN adds four saturating 32-bit counters.
// Each counter counts the cycles in which its cause wins the StallBus or
// the flush.
// ---------------------------------------------------------------------------
module pipe_stall_ctrl #(
    parameter int STALL_W      = 6,
    parameter int DIV_TIMEOUT  = 40,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stallreq_id,
    input  logic               stallreq_mem,
    input  logic               div_start,
    input  logic               div_ready,
    input  logic               excp_req,
    input  logic [31:0]        excp_pc,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               div_cancel,
    output logic               div_timeout
`ifdef STALL_PERF_EN
    ,
    output logic [31:0]        perf_id_cnt,
    output logic [31:0]        perf_ex_cnt,
    output logic [31:0]        perf_mem_cnt,
    output logic [31:0]        perf_flush_cnt
`endif
);

    // The shared wait counter is at least 6 bits and wide enough for
    // both the divide and flush limits.
    localparam int CNT_MAX = (DIV_TIMEOUT > FLUSH_CYCLES) ? DIV_TIMEOUT : FLUSH_CYCLES;
    localparam int CNT_W   = ($clog2(CNT_MAX + 1) > 6) ? $clog2(CNT_MAX + 1) : 6;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(DIV_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST   = CNT_W'(FLUSH_CYCLES - 1);

    localparam logic [STALL_W-1:0] STALL_ID  = STALL_W'(6'b000111);
    localparam logic [STALL_W-1:0] STALL_EX  = STALL_W'(6'b001111);
    localparam logic [STALL_W-1:0] STALL_MEM = STALL_W'(6'b011111);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DIV_WAIT = 2'd1,
        ST_FLUSH    = 2'd2
    } state_e;

    // This names the cause that owns the StallBus in the current cycle.
    typedef enum logic [2:0] {
        CAUSE_NONE  = 3'd0,
        CAUSE_ID    = 3'd1,
        CAUSE_EX    = 3'd2,
        CAUSE_MEM   = 3'd3,
        CAUSE_FLUSH = 3'd4
    } cause_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic [31:0]        pc_q, pc_d;
    logic               flush_q, flush_d;
    logic [31:0]        new_pc_q, new_pc_d;
    logic               div_cancel_q, div_cancel_d;
    logic               div_timeout_q, div_timeout_d;
    cause_e             cause;

    // The wait counter saturates instead of wrapping.
    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    // Next-state, counter, latched-PC and cause selection.
    always_comb begin
        // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_d          = pc_q;
        flush_d       = 1'b0;
        new_pc_d      = 32'h0;
        div_cancel_d  = 1'b0;
        div_timeout_d = 1'b0;
        cause         = CAUSE_NONE;

        unique case (state_q)
            ST_IDLE: begin
                if (excp_req) begin
                    // Accept the exception. The bus stays free in this cycle.
                    pc_d    = excp_pc;
                    cnt_d   = '0;
                    state_d = ST_FLUSH;
                end else if (stallreq_mem) begin
                    // Hold EX as well. A pending div_start is presented
                    // again once MEM releases.
                    cause = CAUSE_MEM;
                end else if (div_start) begin
                    cause   = CAUSE_EX;
                    cnt_d   = '0;
                    state_d = ST_DIV_WAIT;
                end else if (stallreq_id) begin
                    cause = CAUSE_ID;
                end
            end

            ST_DIV_WAIT: begin
                if (excp_req) begin
                    // The exception wins over a same-cycle div_ready.
                    pc_d         = excp_pc;
                    cnt_d        = '0;
                    div_cancel_d = 1'b1;
                    state_d      = ST_FLUSH;
                end else if (div_ready) begin
                    cause   = stallreq_mem ? CAUSE_MEM : CAUSE_NONE;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cause = stallreq_mem ? CAUSE_MEM : CAUSE_EX;
                    cnt_d = cnt_inc;
                    if (cnt_inc >= TIMEOUT_LAST) begin
                        // This is the last stalled cycle. Release next cycle and abort the divider.
                        cnt_d         = '0;
                        div_timeout_d = 1'b1;
                        div_cancel_d  = 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end

            ST_FLUSH: begin
                cause = CAUSE_FLUSH;
                if (cnt_q >= FLUSH_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // The flush outputs are registered. They follow the state being entered.
        if (state_d == ST_FLUSH) begin
            flush_d  = 1'b1;
            new_pc_d = pc_d;
        end
    end

    // The StallBus is combinational from the winning cause and is forced clear while in reset.
    always_comb begin
        stall = '0;
        if (rst_n) begin
            unique case (cause)
                CAUSE_ID:  stall = STALL_ID;
                CAUSE_EX:  stall = STALL_EX;
                CAUSE_MEM: stall = STALL_MEM;
                default:   stall = '0;
            endcase
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            pc_q          <= 32'h0;
            flush_q       <= 1'b0;
            new_pc_q      <= 32'h0;
            div_cancel_q  <= 1'b0;
            div_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            pc_q          <= pc_d;
            flush_q       <= flush_d;
            new_pc_q      <= new_pc_d;
            div_cancel_q  <= div_cancel_d;
            div_timeout_q <= div_timeout_d;
        end
    end

    assign flush       = flush_q;
    assign new_pc      = new_pc_q;
    assign div_cancel  = div_cancel_q;
    assign div_timeout = div_timeout_q;

`ifdef STALL_PERF_EN
    logic [31:0] perf_id_q,    perf_id_d;
    logic [31:0] perf_ex_q,    perf_ex_d;
    logic [31:0] perf_mem_q,   perf_mem_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Only the cause that owns the bus or the flush in this cycle advances its counter.
    always_comb begin
        perf_id_d    = perf_id_q;
        perf_ex_d    = perf_ex_q;
        perf_mem_d   = perf_mem_q;
        perf_flush_d = perf_flush_q;
        unique case (cause)
            CAUSE_ID:    perf_id_d    = sat_inc32(perf_id_q);
            CAUSE_EX:    perf_ex_d    = sat_inc32(perf_ex_q);
            CAUSE_MEM:   perf_mem_d   = sat_inc32(perf_mem_q);
            CAUSE_FLUSH: perf_flush_d = sat_inc32(perf_flush_q);
            default:     ;
        endcase
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_id_q    <= 32'h0;
            perf_ex_q    <= 32'h0;
            perf_mem_q   <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            perf_id_q    <= perf_id_d;
            perf_ex_q    <= perf_ex_d;
            perf_mem_q   <= perf_mem_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_id_cnt    = perf_id_q;
    assign perf_ex_cnt    = perf_ex_q;
    assign perf_mem_cnt   = perf_mem_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_stall_ctrl
// This is the self-checking bench for pipe_stall_ctrl in its default build.
//
// The reference model tracks the controller in plain terms:
//   - whether a divide is outstanding, and how many stall cycles it has used;
//   - how many flush cycles remain;
//   - which pulses are due in the current cycle.
// Every cycle, the expected outputs are derived from that model.
//
// Inputs are driven on the falling edge. Outputs are sampled just after it.
// ---------------------------------------------------------------------------
module tb_pipe_stall_ctrl;

    localparam int STALL_W      = 6;
    localparam int DIV_TIMEOUT  = 40;
    localparam int FLUSH_CYCLES = 1;

    localparam logic [5:0] ENC_ID  = 6'b000111;
    localparam logic [5:0] ENC_EX  = 6'b001111;
    localparam logic [5:0] ENC_MEM = 6'b011111;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               stallreq_id = 1'b0;
    logic               stallreq_mem = 1'b0;
    logic               div_start = 1'b0;
    logic               div_ready = 1'b0;
    logic               excp_req = 1'b0;
    logic [31:0]        excp_pc = 32'h0;
    logic [STALL_W-1:0] stall;
    logic               flush;
    logic [31:0]        new_pc;
    logic               div_cancel;
    logic               div_timeout;

    int checks = 0;
    int errors = 0;

    pipe_stall_ctrl #(
        .STALL_W      (STALL_W),
        .DIV_TIMEOUT  (DIV_TIMEOUT),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stallreq_id  (stallreq_id),
        .stallreq_mem (stallreq_mem),
        .div_start    (div_start),
        .div_ready    (div_ready),
        .excp_req     (excp_req),
        .excp_pc      (excp_pc),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .div_cancel   (div_cancel),
        .div_timeout  (div_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ----------------------------- reference model -----------------------------
    bit          m_div_busy   = 1'b0;
    int          m_div_stalls = 0;
    int          m_flush_left = 0;
    bit          m_cancel     = 1'b0;
    bit          m_timeout    = 1'b0;
    logic [31:0] m_pc         = 32'h0;

    always @(posedge clk or negedge rst_n) begin : model_step
        bit c;
        bit t;
        c = 1'b0;
        t = 1'b0;
        if (!rst_n) begin
            m_div_busy   = 1'b0;
            m_div_stalls = 0;
            m_flush_left = 0;
            m_pc         = 32'h0;
        end else if (m_flush_left > 0) begin
            m_flush_left--;
        end else if (excp_req) begin
            m_pc         = excp_pc;
            m_flush_left = FLUSH_CYCLES;
            c            = m_div_busy;
            m_div_busy   = 1'b0;
        end else if (m_div_busy) begin
            if (div_ready) begin
                m_div_busy = 1'b0;
            end else begin
                m_div_stalls++;
                if (m_div_stalls >= DIV_TIMEOUT) begin
                    m_div_busy = 1'b0;
                    c = 1'b1;
                    t = 1'b1;
                end
            end
        end else if (div_start && !stallreq_mem) begin
            m_div_busy   = 1'b1;
            m_div_stalls = 1;
        end
        m_cancel  = c;
        m_timeout = t;
    end

    function automatic logic [5:0] exp_stall();
        if (!rst_n || m_flush_left > 0 || excp_req) return 6'b0;
        if (m_div_busy) return stallreq_mem ? ENC_MEM : (div_ready ? 6'b0 : ENC_EX);
        if (stallreq_mem) return ENC_MEM;
        if (div_start)    return ENC_EX;
        if (stallreq_id)  return ENC_ID;
        return 6'b0;
    endfunction

    // The compare process checks every output against the model once per cycle.
    always @(negedge clk) begin : compare
        logic fl;
        #1;
        fl = rst_n && (m_flush_left > 0);
        check("stall",       32'(stall),       32'(exp_stall()));
        check("flush",       32'(flush),       32'(fl));
        check("new_pc",      new_pc,           fl ? m_pc : 32'h0);
        check("div_cancel",  32'(div_cancel),  32'(rst_n && m_cancel));
        check("div_timeout", 32'(div_timeout), 32'(rst_n && m_timeout));
    end

    // ------------------------------- stimulus ----------------------------------
    task automatic drive(input logic id, input logic mem, input logic ds, input logic dr,
                         input logic ex, input logic [31:0] pc);
        @(negedge clk);
        stallreq_id  = id;
        stallreq_mem = mem;
        div_start    = ds;
        div_ready    = dr;
        excp_req     = ex;
        excp_pc      = pc;
        #2;
    endtask

    initial begin
        int n;
        // Reset: the bus stays clear even with a request present.
        stallreq_id = 1'b1;
        #7;
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_new_pc", new_pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stallreq_id = 1'b0;

        // One-cycle load-use request.
        drive(1, 0, 0, 0, 0, 0);
        check("id_stall", 32'(stall), 32'h07);
        check("id_flush", 32'(flush), 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        check("id_release", 32'(stall), 32'h00);

        // A divide that completes after 5 stall cycles.
        drive(0, 0, 1, 0, 0, 0);
        check("div5_c0", 32'(stall), 32'h0F);
        for (int i = 1; i < 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            check("div5_wait", 32'(stall), 32'h0F);
        end
        drive(0, 0, 0, 1, 0, 0);
        check("div5_ready", 32'(stall), 32'h00);
        drive(0, 0, 0, 0, 0, 0);
        check("div5_no_timeout", 32'(div_timeout), 32'h0);
        check("div5_no_cancel", 32'(div_cancel), 32'h0);

        // A divide with no div_ready hits the timeout.
        drive(0, 0, 1, 0, 0, 0);
        check("to_start", 32'(stall), 32'h0F);
        n = 1;
        for (int i = 0; i < 100; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            if (stall == 6'h0F) n++;
            else break;
        end
        check("to_stall_cycles", 32'(n), 32'd40);
        check("to_timeout_pulse", 32'(div_timeout), 32'h1);
        check("to_cancel_pulse", 32'(div_cancel), 32'h1);
        check("to_stall_after", 32'(stall), 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        check("to_timeout_1cyc", 32'(div_timeout), 32'h0);
        check("to_cancel_1cyc", 32'(div_cancel), 32'h0);

        // An exception during a divide wait, with div_ready in the same cycle.
        drive(0, 0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 1, 32'hBFC0_0380);
        check("ex_stall", 32'(stall), 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        check("ex_flush", 32'(flush), 32'h1);
        check("ex_new_pc", new_pc, 32'hBFC0_0380);
        check("ex_cancel", 32'(div_cancel), 32'h1);
        check("ex_flush_stall", 32'(stall), 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        check("ex_flush_end", 32'(flush), 32'h0);
        check("ex_cancel_end", 32'(div_cancel), 32'h0);

        // All requests at once: MEM wins, and the divide is taken once MEM drops.
        drive(1, 1, 1, 0, 0, 0);
        check("prio_mem", 32'(stall), 32'h1F);
        drive(1, 1, 1, 0, 0, 0);
        check("prio_mem_hold", 32'(stall), 32'h1F);
        drive(1, 0, 1, 0, 0, 0);
        check("prio_ex", 32'(stall), 32'h0F);
        drive(0, 0, 0, 1, 0, 0);
        check("prio_done", 32'(stall), 32'h00);

        // Asynchronous reset in the middle of a flush.
        drive(0, 0, 0, 0, 1, 32'h1234_5678);
        drive(0, 0, 0, 0, 0, 0);
        check("arst_flush_pre", 32'(flush), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        check("arst_flush", 32'(flush), 32'h0);
        check("arst_new_pc", new_pc, 32'h0);
        check("arst_cancel", 32'(div_cancel), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h8000_0180);
        check("arst_ex_stall", 32'(stall), 32'h0);
        drive(0, 0, 0, 0, 0, 0);
        check("arst_ex_flush", 32'(flush), 32'h1);
        check("arst_ex_new_pc", new_pc, 32'h8000_0180);

        // Randomised traffic, checked cycle by cycle by the compare process.
        for (int i = 0; i < 4000; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 500) % 2 == 0) ? 20 : 3;
            drive($urandom_range(0, 99) < 30,
                  $urandom_range(0, 99) < 20,
                  $urandom_range(0, 99) < 15,
                  $urandom_range(0, 99) < rdy_pct,
                  $urandom_range(0, 99) < 3,
                  $urandom);
        end

        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central pipeline control for the five-stage MIPS core. Merges stall requests from ID (load-use), EX (multi-cycle divide) and MEM (data SRAM wait) into the StallBus consumed by the PC, IF, ID, EX, MEM and WB pipeline registers. Sequences multi-cycle divide waits and exception flushes, and supplies the redirect PC on a flush.

Parameters:
STALL_W, 6, width of stall bus; bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; 1 = Stop
DIV_TIMEOUT, 40, max cycles in DIV_WAIT before forced release
FLUSH_CYCLES, 1, cycles flush is held after an exception is accepted (>=1)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
stallreq_id  in  1  load-use hazard from ID (combinational, same cycle)
stallreq_mem  in  1  data SRAM not ready in MEM
div_start  in  1  EX issues a divide this cycle
div_ready  in  1  divider result valid this cycle
excp_req  in  1  exception/eret detected in MEM
excp_pc  in  32  redirect target for excp_req
stall  out  STALL_W  StallBus to all pipeline registers
flush  out  1  clear IF/ID/EX/MEM pipeline registers
new_pc  out  32  redirect PC, valid while flush=1
div_cancel  out  1  one-cycle pulse aborting the divider
div_timeout  out  1  one-cycle pulse, divide wait expired

Behaviour:
- States: IDLE, DIV_WAIT, FLUSH. Reset (rst_n=0, async): state=IDLE, counters=0, latched PC=0; stall=0, flush=0, new_pc=0, div_cancel=0, div_timeout=0 while reset is asserted.
- stall is combinational from the current state and requests (zero latency); flush, new_pc and the pulses are registered-state driven.
- Stall encodings: ID req -> 6'b000111 (bubble into EX); EX divide wait -> 6'b001111; MEM req -> 6'b011111. Priority when several requests are active: FLUSH state > MEM > EX > ID; the highest cause wins, with no OR-merging.
- IDLE: stall per priority. excp_req=1 -> latch excp_pc, next state FLUSH, stall=0 this cycle. Otherwise div_start=1 and stallreq_mem=0 -> DIV_WAIT, counter=0, stall=6'b001111 this cycle. div_start while stallreq_mem=1 -> stay IDLE; EX is frozen and re-presents div_start.
- DIV_WAIT: div_ready=1 -> stall=0 (or MEM encoding if stallreq_mem), next IDLE. Else stall=6'b001111 (MEM encoding overrides), counter++. counter==DIV_TIMEOUT-1 without ready -> div_timeout pulse and div_cancel pulse next cycle, next IDLE. excp_req -> div_cancel pulse, latch excp_pc, next FLUSH; excp_req takes precedence over a simultaneous div_ready.
- FLUSH: flush=1, new_pc=latched PC, stall=0, held FLUSH_CYCLES cycles via counter, then IDLE. excp_req, div_start and stallreq_* are ignored while in FLUSH.
- Pulses are exactly one cycle. Counter is 6 bits minimum and saturates, never wraps.
- Reset asserted mid-DIV_WAIT or mid-FLUSH returns to IDLE immediately; no div_cancel is emitted.

Optional Feature:
STALL_PERF_EN: when defined, adds output ports perf_id_cnt, perf_ex_cnt, perf_mem_cnt and perf_flush_cnt (32 bits each, reset 0). Each counter increments once per cycle in which its cause selects the stall or flush, saturates at 32'hFFFF_FFFF, and counts the winning cause only. When undefined, these ports and counters do not exist and the remaining behaviour is unchanged.

Test Plan:
- stallreq_id=1 for 1 cycle in IDLE -> stall=6'b000111 that cycle, 6'b000000 next; flush stays 0.
- div_start, div_ready after 5 cycles -> stall=6'b001111 for 5 cycles, then 0 on the ready cycle; state returns to IDLE; no div_timeout.
- div_start with div_ready never asserted, DIV_TIMEOUT=40 -> 40 stall cycles, then single-cycle div_timeout and div_cancel, stall=0 after.
- excp_req with excp_pc=32'hBFC0_0380 during DIV_WAIT, simultaneous div_ready -> div_cancel pulse; next cycle flush=1, new_pc=32'hBFC0_0380 for FLUSH_CYCLES cycles; stall=0.
- stallreq_id, stallreq_mem and div_start all 1 in IDLE -> stall=6'b011111, state stays IDLE; after mem drops, div_start accepted -> 6'b001111.
- rst_n dropped mid-FLUSH (asynchronous, no clock edge) -> flush and new_pc go to 0 immediately; after release, state is IDLE and excp_req is accepted normally.
